// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous RAM between the core's instruction-fetch
// port (i_*) and data-access port (d_*). Each cycle at most one requester is
// granted. The winner drives the RAM address, write enable and write data. Read
// data is steered back to the winner one cycle later. A small response FSM
// remembers which port owns the read data currently coming out of the RAM.
//
// Parameters:
//   WIDTH       data word width in bits
//   ADDRBITS    byte-address width (RAM is word addressed: ADDRBITS-2 bits)
//   STARVE_MAX  consecutive lost cycles before the fetch port is forced to win
//               (only meaningful with ARB_STARVE_GUARD_EN)
//
// Optional feature (compile-time macro):
//   ARB_STARVE_GUARD_EN  when defined, a saturating starvation counter lets the
//                        fetch port win over the data port for one cycle after
//                        STARVE_MAX consecutive lost cycles. When undefined,
//                        the data port has strict priority.
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   reset      in   asynchronous active-low reset
//   i_req      in   fetch request, held with i_addr until i_gnt
//   i_addr     in   fetch byte address
//   i_gnt      out  fetch accepted this cycle (combinational)
//   i_rdata    out  fetch read data
//   i_rvalid   out  i_rdata valid, one cycle after i_gnt
//   d_req      in   data request, held with d_we/d_addr/d_wdata until d_gnt
//   d_we       in   1 = store, 0 = load
//   d_addr     in   data byte address
//   d_wdata    in   store data
//   d_gnt      out  data request accepted this cycle (combinational)
//   d_rdata    out  load data
//   d_rvalid   out  d_rdata valid, one cycle after a load grant
//   mem_en     out  RAM access this cycle
//   mem_we     out  RAM write this cycle
//   mem_addr   out  RAM word address (byte address >> 2)
//   mem_wdata  out  RAM write data
//   mem_rdata  in   RAM read data, valid the cycle after a read
//   busy       out  a read response is being returned this cycle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDRBITS   = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDRBITS-1:0]   i_addr,
  output logic                  i_gnt,
  output logic [WIDTH-1:0]      i_rdata,
  output logic                  i_rvalid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDRBITS-1:0]   d_addr,
  input  logic [WIDTH-1:0]      d_wdata,
  output logic                  d_gnt,
  output logic [WIDTH-1:0]      d_rdata,
  output logic                  d_rvalid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDRBITS-3:0]   mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  busy
);

  // Which port owns the RAM read data arriving this cycle.
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_I    = 2'd1,
    R_D    = 2'd2
  } resp_state_e;

  resp_state_e          resp_state_q, resp_state_d;
  logic [WIDTH-1:0]     i_rdata_q, i_rdata_d;
  logic [WIDTH-1:0]     d_rdata_q, d_rdata_d;
  logic                 fetch_wins;

  // ---------------------------------------------------------------------------
  // Starvation guard
  // ---------------------------------------------------------------------------
`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  // Once the fetch port has lost STARVE_MAX cycles in a row it takes the RAM
  // for exactly one cycle; the grant clears the counter again.
  assign fetch_wins = i_req && (starve_cnt_q == STARVE_LIMIT);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!i_req || i_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_LIMIT) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign fetch_wins = 1'b0;

  // STARVE_MAX only sizes the guard counter; keep it referenced.
  logic unused_starve_max;
  assign unused_starve_max = (STARVE_MAX != 0);
`endif

  // ---------------------------------------------------------------------------
  // Arbitration: at most one grant per cycle, data port first unless the
  // starvation guard fires. Grants are forced low while reset is asserted so
  // nothing reaches the RAM during reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset) begin
      if (fetch_wins) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RAM address / data muxing. The two low byte-address bits are dropped
  // without any alignment check.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = i_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr[ADDRBITS-1:2];
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_addr  = i_addr[ADDRBITS-1:2];
    end
  end

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Response FSM. Updated every cycle so back-to-back grants yield
  // back-to-back responses. Stores never produce a response.
  // ---------------------------------------------------------------------------
  always_comb begin
    resp_state_d = R_IDLE;
    if (i_gnt) begin
      resp_state_d = R_I;
    end else if (d_gnt && !d_we) begin
      resp_state_d = R_D;
    end
  end

  // Capture registers keep the last delivered word visible on rdata while
  // rvalid is low; during the response cycle the RAM output passes straight
  // through so there is no extra cycle of latency.
  always_comb begin
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (resp_state_q == R_I) begin
      i_rdata_d = mem_rdata;
    end
    if (resp_state_q == R_D) begin
      d_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_state_q <= R_IDLE;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      resp_state_q <= resp_state_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign i_rvalid = (resp_state_q == R_I);
  assign d_rvalid = (resp_state_q == R_D);
  assign i_rdata  = i_rvalid ? mem_rdata : i_rdata_q;
  assign d_rdata  = d_rvalid ? mem_rdata : d_rdata_q;
  assign busy     = (resp_state_q != R_IDLE);

endmodule
